// File: rtl/step_conditioner.sv
// Conditions a bouncy pushbutton and a data switch into a clean one-cycle step pulse,
// a press-sampled data bit, a debounced button level and a wrapping press counter.
module step_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       key_n,
  input  logic       w_raw,
  output logic       step,
  output logic       w_out,
  output logic       key_down,
  output logic [7:0] step_count
);

  localparam int unsigned STEP_CNT_W = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic                  key_meta_q, key_s_q;
  logic                  w_meta_q, w_s_q;
  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  step_q, step_d;
  logic                  w_out_q, w_out_d;
  logic                  key_down_q, key_down_d;
  logic [STEP_CNT_W-1:0] step_count_q, step_count_d;

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = 1'b0;
    w_out_d      = w_out_q;
    step_count_d = step_count_q;
    case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = PRESSED;
          step_d       = 1'b1;
          w_out_d      = w_s_q;
          step_count_d = step_count_q + STEP_CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (key_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    key_down_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // Synchronizers reset to the idle input levels (button released, switch low)
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      key_meta_q   <= 1'b1;
      key_s_q      <= 1'b1;
      w_meta_q     <= 1'b0;
      w_s_q        <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      step_q       <= 1'b0;
      w_out_q      <= 1'b0;
      key_down_q   <= 1'b0;
      step_count_q <= '0;
    end else begin
      key_meta_q   <= key_n;
      key_s_q      <= key_meta_q;
      w_meta_q     <= w_raw;
      w_s_q        <= w_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      w_out_q      <= w_out_d;
      key_down_q   <= key_down_d;
      step_count_q <= step_count_d;
    end
  end

  assign step       = step_q;
  assign w_out      = w_out_q;
  assign key_down   = key_down_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_conditioner.sv
// Scoreboard bench for step_conditioner: a run-length debounce model predicts step events
// and debounced levels; a negedge monitor compares them against the DUT.
module tb_step_conditioner;

  localparam int unsigned D  = 4;
  localparam int unsigned CW = 8;

  logic       Clock;
  logic       Resetn;
  logic       key_n;
  logic       w_raw;
  logic       step;
  logic       w_out;
  logic       key_down;
  logic [7:0] step_count;

  step_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)) dut (
    .Clock(Clock), .Resetn(Resetn), .key_n(key_n), .w_raw(w_raw),
    .step(step), .w_out(w_out), .key_down(key_down), .step_count(step_count)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    int unsigned cyc;
    logic        w;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int          steps_seen = 0;

  // Model state: inputs seen two edges late, debounced level, run length of disagreeing samples
  logic       kq[$];
  logic       wq[$];
  logic       m_level = 1'b0;
  logic       m_w = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  int         run = 0;

  task automatic chk(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, req);
    end
  endtask

  initial begin
    kq = {1'b1, 1'b1};
    wq = {1'b0, 1'b0};
  end

  always @(posedge Clock) begin : model
    logic ks, ws, lvl_in;
    cyc++;
    if (!Resetn) begin
      kq = {1'b1, 1'b1};
      wq = {1'b0, 1'b0};
      m_level = 1'b0;
      m_w = 1'b0;
      m_cnt = 8'd0;
      run = 0;
      exp_q.delete();
    end else begin
      ks = kq.pop_front();
      ws = wq.pop_front();
      kq.push_back(key_n);
      wq.push_back(w_raw);
      lvl_in = !ks;
      if (lvl_in != m_level) run++;
      else run = 0;
      if (run == int'(D) + 1) begin
        m_level = lvl_in;
        run = 0;
        if (m_level) begin
          m_cnt = m_cnt + 8'd1;
          m_w = ws;
          exp_q.push_back('{cyc, ws, m_cnt});
        end
      end
    end
  end

  always @(negedge Clock) begin : monitor
    logic exp_step;
    exp_t e;
    if (Resetn) begin
      chk("key_down", int'(key_down), int'(m_level));
      chk("w_out", int'(w_out), int'(m_w));
      chk("step_count", int'(step_count), int'(m_cnt));
      exp_step = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
      chk("step", int'(step), int'(exp_step));
      if (step) steps_seen++;
      if (exp_step) begin
        e = exp_q.pop_front();
        chk("step_time", int'(cyc), int'(e.cyc));
        chk("step_w_out", int'(w_out), int'(e.w));
        chk("step_cnt", int'(step_count), int'(e.cnt));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic press(input logic w, input int hold, input int gap);
    w_raw = w;
    key_n = 1'b0;
    cycles(hold);
    key_n = 1'b1;
    cycles(gap);
  endtask

  task automatic do_reset(input int n);
    Resetn = 1'b0;
    cycles(n);
    Resetn = 1'b1;
  endtask

  initial begin : stim
    int s0;
    Resetn = 1'b0;
    key_n  = 1'b1;
    w_raw  = 1'b0;
    cycles(3);
    Resetn = 1'b1;
    cycles(6);

    // Clean press
    press(1'b1, 20, 12);
    chk("clean_count", int'(step_count), 1);

    // Press bounce: low 3, high 1, then stable low
    w_raw = 1'b0;
    key_n = 1'b0; cycles(3);
    key_n = 1'b1; cycles(1);
    press(1'b0, 15, 12);
    chk("bounce_count", int'(step_count), 2);

    // Release bounce while held
    s0 = steps_seen;
    key_n = 1'b0; cycles(15);
    key_n = 1'b1; cycles(2);
    key_n = 1'b0; cycles(10);
    chk("rel_bounce_down", int'(key_down), 1);
    key_n = 1'b1; cycles(12);
    chk("rel_bounce_steps", steps_seen - s0, 1);

    // Sampling: switch change while held is not reflected
    w_raw = 1'b0;
    key_n = 1'b0; cycles(10);
    w_raw = 1'b1; cycles(10);
    chk("held_w_out", int'(w_out), 0);
    key_n = 1'b1; cycles(12);
    press(1'b1, 12, 12);
    chk("second_w_out", int'(w_out), 1);
    for (int i = 0; i < 4; i++) press(1'b1, 10, 10);

    // Asynchronous reset while held with a nonzero count
    w_raw = 1'b1;
    key_n = 1'b0;
    cycles(12);
    @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("rst_step", int'(step), 0);
    chk("rst_w_out", int'(w_out), 0);
    chk("rst_key_down", int'(key_down), 0);
    chk("rst_count", int'(step_count), 0);
    key_n = 1'b1;
    cycles(3);
    Resetn = 1'b1;
    cycles(12);
    chk("idle_after_rst", steps_seen, steps_seen);

    // Wrap after 256 presses from reset
    do_reset(2);
    cycles(2);
    s0 = steps_seen;
    for (int i = 0; i < 256; i++) press(1'(i % 2), 10, 10);
    chk("wrap_count", int'(step_count), 0);
    chk("wrap_steps", steps_seen - s0, 256);

    // Reset at cycle 5 of a press; button still held afterwards
    s0 = steps_seen;
    key_n = 1'b0;
    cycles(5);
    Resetn = 1'b0;
    cycles(3);
    chk("rst5_no_step", steps_seen - s0, 0);
    Resetn = 1'b1;
    cycles(6);
    chk("rst5_not_yet", steps_seen - s0, 0);
    cycles(6);
    chk("rst5_fresh", steps_seen - s0, 1);
    key_n = 1'b1;
    cycles(12);

    // Random bouncy stimulus
    for (int i = 0; i < 400; i++) begin
      key_n = 1'($urandom_range(0, 1));
      w_raw = 1'($urandom_range(0, 1));
      cycles(int'($urandom_range(1, 12)));
    end
    key_n = 1'b1;
    cycles(20);
    chk("pending_steps", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
